// File: rtl/dmem_access_unit_if.sv
// Request/response and data-memory signal bundle for dmem_access_unit.
// master: the CPU pipeline plus the data memory, which drive requests and read data.
// slave: the access unit, which answers requests and drives the memory controls.
interface dmem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] DMEM_address;
  logic [31:0] DMEM_data_in;
  logic        DMEM_mem_write;
  logic        DMEM_mem_read;
  logic [31:0] DMEM_data_out;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output DMEM_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  DMEM_data_out,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Byte/half/word load-store initiator for a 256 x 32 word memory; sub-word stores use read-modify-write.
// Latency from accept edge: error 1, load 2, word store 2, sub-word store 3 cycles.
// One request in flight; req_ready is high only in IDLE, so the requester holds req_valid until accepted.
module dmem_access_unit #(
  parameter int MEM_WORDS = 256,
  parameter int WORD_AW   = 8
) (
  input  logic           clk,
  input  logic           SYS_reset_n,
  dmem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_addr_lo;
  logic [1:0]  r_size;
  logic        r_write;
  logic        r_unsigned;
  logic [15:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_error;
  logic [31:0] r_address;
  logic [31:0] r_data_in;

  logic        w_req_err;
  logic [31:0] w_word_idx;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_word_idx = {{(32-WORD_AW){1'b0}}, bus.req_addr[WORD_AW+1:2]};

  // Classify the incoming request: illegal size, misalignment, or beyond the memory.
  always_comb begin
    w_req_err = 1'b0;
    case (bus.req_size)
      2'b00:   w_req_err = 1'b0;
      2'b01:   w_req_err = bus.req_addr[0];
      2'b10:   w_req_err = |bus.req_addr[1:0];
      default: w_req_err = 1'b1;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS)) w_req_err = 1'b1;
  end

  // Lane extraction and extension for loads, lane merge for sub-word stores.
  always_comb begin
    w_byte = bus.DMEM_data_out[{r_addr_lo, 3'b000} +: 8];
    w_half = r_addr_lo[1] ? bus.DMEM_data_out[31:16] : bus.DMEM_data_out[15:0];
    case (r_size)
      2'b00:   w_load_data = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
      2'b01:   w_load_data = {{16{w_half[15] & ~r_unsigned}}, w_half};
      default: w_load_data = bus.DMEM_data_out;
    endcase
    w_merged = bus.DMEM_data_out;
    if (r_size == 2'b00) w_merged[{r_addr_lo, 3'b000} +: 8] = r_wdata[7:0];
    else                 w_merged[{r_addr_lo[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!SYS_reset_n) r_state <= IDLE;
    else              r_state <= w_next;
  end

  // Next-state decode; sub-word stores read first, word stores write directly.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (w_req_err)                        w_next = RESP;
          else if (!bus.req_write)              w_next = RD;
          else if (bus.req_size == 2'b10)       w_next = WR;
          else                                  w_next = RD;
        end
      end
      RD:      w_next = r_write ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, load result and write-word datapath.
  always_ff @(posedge clk) begin
    if (!SYS_reset_n) begin
      r_addr_lo  <= 2'b00;
      r_size     <= 2'b00;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_wdata    <= 16'h0;
      r_rdata    <= 32'h0;
      r_error    <= 1'b0;
      r_address  <= 32'h0;
      r_data_in  <= 32'h0;
    end else begin
      if (r_state == IDLE && bus.req_valid) begin
        r_addr_lo  <= bus.req_addr[1:0];
        r_size     <= bus.req_size;
        r_write    <= bus.req_write;
        r_unsigned <= bus.req_unsigned;
        r_wdata    <= bus.req_wdata[15:0];
        r_rdata    <= 32'h0;
        r_error    <= w_req_err;
        r_address  <= w_word_idx;
        r_data_in  <= bus.req_wdata;
      end else if (r_state == RD) begin
        if (r_write) r_data_in <= w_merged;
        else         r_rdata   <= w_load_data;
      end
    end
  end

  assign bus.req_ready      = (r_state == IDLE);
  assign bus.resp_valid     = (r_state == RESP);
  assign bus.resp_rdata     = r_rdata;
  assign bus.resp_error     = r_error;
  assign bus.DMEM_mem_read  = (r_state == RD);
  assign bus.DMEM_mem_write = (r_state == WR);
  assign bus.DMEM_address   = r_address;
  assign bus.DMEM_data_in   = r_data_in;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed vector bench for dmem_access_unit with a behavioural 256-word memory.
// Memory reads combinationally while mem_read is high and commits writes on the falling edge.
// Each request is checked for latency, result, error, enables, address and written word.
module tb_dmem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   overlap = 0;

  logic [31:0] mem [256];

  dmem_access_unit_if bus();

  dmem_access_unit #(.MEM_WORDS(256), .WORD_AW(8)) dut (
    .clk         (clk),
    .SYS_reset_n (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  assign bus.DMEM_data_out = bus.DMEM_mem_read ? mem[bus.DMEM_address[7:0]] : 32'h0;

  always @(negedge clk) begin
    if (bus.DMEM_mem_write) mem[bus.DMEM_address[7:0]] <= bus.DMEM_data_in;
    if (bus.DMEM_mem_write && bus.DMEM_mem_read) overlap++;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_wdat;
  } vec_t;

  vec_t vt [$];

  function automatic vec_t mk(logic wr, logic [1:0] sz, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] er, logic ee, int el,
                              logic [31:0] ew);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_wdat = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output logic saw_rd, output logic saw_wr,
                         output logic [31:0] rd_addr, output logic [31:0] wr_dat,
                         output logic rdy0, output logic rdy_resp);
    @(negedge clk);
    rdy0 = bus.req_ready;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0; rdata = 32'hx; err = 1'bx; saw_rd = 1'b0; saw_wr = 1'b0;
    rd_addr = 32'h0; wr_dat = 32'h0; rdy_resp = 1'bx;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (bus.DMEM_mem_read)  begin saw_rd = 1'b1; rd_addr = bus.DMEM_address; end
      if (bus.DMEM_mem_write) begin saw_wr = 1'b1; wr_dat = bus.DMEM_data_in; end
      if (bus.resp_valid) begin
        lat = n; rdata = bus.resp_rdata; err = bus.resp_error; rdy_resp = bus.req_ready;
        break;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rdata, rd_addr, wr_dat;
    logic        err, saw_rd, saw_wr, rdy0, rdy_resp;
    logic        exp_rd, exp_wr;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]   = 32'h01020304;
    mem[5]   = 32'h8899AABB;
    mem[255] = 32'h7F000000;

    // wr sz uns addr wdata exp_rdata err lat exp_wdat
    vt.push_back(mk(0, 2'b00, 0, 32'h15, 32'h0, 32'hFFFFFFAA, 0, 2, 32'h0));
    vt.push_back(mk(0, 2'b00, 1, 32'h15, 32'h0, 32'h000000AA, 0, 2, 32'h0));
    vt.push_back(mk(0, 2'b01, 1, 32'h16, 32'h0, 32'h00008899, 0, 2, 32'h0));
    vt.push_back(mk(0, 2'b01, 0, 32'h14, 32'h0, 32'hFFFFAABB, 0, 2, 32'h0));
    vt.push_back(mk(0, 2'b01, 0, 32'h16, 32'h0, 32'hFFFF8899, 0, 2, 32'h0));
    vt.push_back(mk(0, 2'b00, 0, 32'h14, 32'h0, 32'hFFFFFFBB, 0, 2, 32'h0));
    vt.push_back(mk(0, 2'b00, 1, 32'h17, 32'h0, 32'h00000088, 0, 2, 32'h0));
    vt.push_back(mk(1, 2'b00, 0, 32'h17, 32'h00000012, 32'h0, 0, 3, 32'h1299AABB));
    vt.push_back(mk(0, 2'b10, 0, 32'h14, 32'h0, 32'h1299AABB, 0, 2, 32'h0));
    vt.push_back(mk(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 32'h0, 0, 2, 32'hDEADBEEF));
    vt.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hDEADBEEF, 0, 2, 32'h0));
    vt.push_back(mk(1, 2'b01, 0, 32'h22, 32'h0000CAFE, 32'h0, 0, 3, 32'hCAFEBEEF));
    vt.push_back(mk(1, 2'b00, 0, 32'h20, 32'hFFFFFF5A, 32'h0, 0, 3, 32'hCAFEBE5A));
    vt.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEBE5A, 0, 2, 32'h0));
    vt.push_back(mk(0, 2'b00, 1, 32'h3FF, 32'h0, 32'h0000007F, 0, 2, 32'h0));
    vt.push_back(mk(0, 2'b01, 0, 32'h3FE, 32'h0, 32'h00007F00, 0, 2, 32'h0));
    vt.push_back(mk(0, 2'b10, 0, 32'h22, 32'h0, 32'h0, 1, 1, 32'h0));
    vt.push_back(mk(1, 2'b01, 0, 32'h13, 32'h0000FFFF, 32'h0, 1, 1, 32'h0));
    vt.push_back(mk(0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1, 1, 32'h0));
    vt.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1, 32'h0));
    vt.push_back(mk(1, 2'b00, 0, 32'h1001, 32'h000000EE, 32'h0, 1, 1, 32'h0));

    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = 32'hFFFFFFFF;

    // Reset with a request pending: it must be ignored and all outputs cleared.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 0, 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_error", 0, 32'(bus.resp_error), 32'h0);
    chk("rst_resp_rdata", 0, bus.resp_rdata, 32'h0);
    chk("rst_mem_read", 0, 32'(bus.DMEM_mem_read), 32'h0);
    chk("rst_mem_write", 0, 32'(bus.DMEM_mem_write), 32'h0);
    chk("rst_address", 0, bus.DMEM_address, 32'h0);
    chk("rst_data_in", 0, bus.DMEM_data_in, 32'h0);
    chk("rst_ready", 0, 32'(bus.req_ready), 32'h1);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;

    // Table-driven transactions, issued back-to-back.
    for (int i = 0; i < vt.size(); i++) begin
      run_req(vt[i].wr, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wdata,
              lat, rdata, err, saw_rd, saw_wr, rd_addr, wr_dat, rdy0, rdy_resp);
      exp_rd = !vt[i].exp_err && (!vt[i].wr || vt[i].sz != 2'b10);
      exp_wr = !vt[i].exp_err && vt[i].wr;
      chk("ready_at_issue", i, 32'(rdy0), 32'h1);
      chk("latency", i, 32'(lat), 32'(vt[i].exp_lat));
      chk("rdata", i, rdata, vt[i].exp_rdata);
      chk("error", i, 32'(err), 32'(vt[i].exp_err));
      chk("ready_in_resp", i, 32'(rdy_resp), 32'h0);
      chk("read_enable_seen", i, 32'(saw_rd), 32'(exp_rd));
      chk("write_enable_seen", i, 32'(saw_wr), 32'(exp_wr));
      if (exp_rd) chk("read_address", i, rd_addr, {24'h0, vt[i].addr[9:2]});
      if (exp_wr) chk("write_word", i, wr_dat, vt[i].exp_wdat);
    end
    chk("err_store_no_write", 0, mem[4], 32'h01020304);

    // Reset landing in the WR cycle: the write still commits, the response is dropped.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h24; bus.req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("wr_reset_write_en", 0, 32'(bus.DMEM_mem_write), 32'h1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("wr_reset_no_resp", k, 32'(bus.resp_valid), 32'h0);
      chk("wr_reset_no_write", k, 32'(bus.DMEM_mem_write), 32'h0);
    end
    rst_n = 1'b1;
    chk("wr_reset_committed", 0, mem[9], 32'h11223344);

    // Reset landing in the read phase of a halfword store: memory must stay unchanged.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h14; bus.req_wdata = 32'h00005555;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rd_reset_read_en", 0, 32'(bus.DMEM_mem_read), 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rd_reset_no_resp", k, 32'(bus.resp_valid), 32'h0);
      chk("rd_reset_no_write", k, 32'(bus.DMEM_mem_write), 32'h0);
    end
    rst_n = 1'b1;
    chk("rd_reset_mem_kept", 0, mem[5], 32'h1299AABB);
    chk("rd_reset_ready", 0, 32'(bus.req_ready), 32'h1);

    run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0,
            lat, rdata, err, saw_rd, saw_wr, rd_addr, wr_dat, rdy0, rdy_resp);
    chk("post_reset_latency", 0, 32'(lat), 32'h2);
    chk("post_reset_rdata", 0, rdata, 32'h1299AABB);
    chk("post_reset_error", 0, 32'(err), 32'h0);

    chk("read_write_overlap", 0, 32'(overlap), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
